// File: rtl/branch_unit.sv
// Branch resolution and prediction for nano_rv32i: six-way RV32I comparator,
// 2-bit saturating-counter BHT, registered redirect/mispredict and perf counters.
module branch_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         PERF_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [XLEN-1:0]   pred_pc_i,
    output logic              pred_taken_o,
    input  logic              valid_i,
    input  logic              branch_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              pred_taken_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    output logic              take_branch_o,
    output logic              mispredict_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              illegal_o,
    output logic [PERF_W-1:0] branch_cnt_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Handshake: a request is a single cycle with valid_i=1; there is no ready,
    // the unit accepts every cycle. flush_i kills the request in that same cycle,
    // and out_valid_o pulses exactly one cycle later for every accepted request.

    logic [1:0]        bht_q [BHT_ENTRIES];
    logic              out_valid_q;
    logic              take_q;
    logic              mispred_q;
    logic              illegal_q;
    logic [XLEN-1:0]   redirect_q;
    logic [PERF_W-1:0] branch_cnt_q;
    logic [PERF_W-1:0] mispred_cnt_q;

    logic              acc;
    logic              illegal;
    logic              cond;
    logic              taken;
    logic              mispred;
    logic              upd;
    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  res_idx;
    logic [1:0]        ctr_d;
    logic [XLEN-1:0]   target_d;
    logic [PERF_W-1:0] branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_d;
    logic              unused_pc_bits;

    assign pred_idx       = pred_pc_i[IDX_W+1:2];
    assign res_idx        = pc_i[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0]};

    // Reads the pre-update counter, so a same-cycle resolve is seen next cycle.
    assign pred_taken_o = bht_q[pred_idx][1];

    assign acc     = valid_i & branch_i & ~flush_i;
    assign illegal = (funct3_i[2:1] == 2'b01);

    always_comb begin
        cond = 1'b0;
        unique case (funct3_i)
            3'b000:  cond = (rs1_i == rs2_i);
            3'b001:  cond = (rs1_i != rs2_i);
            3'b100:  cond = ($signed(rs1_i) <  $signed(rs2_i));
            3'b101:  cond = ($signed(rs1_i) >= $signed(rs2_i));
            3'b110:  cond = (rs1_i <  rs2_i);
            3'b111:  cond = (rs1_i >= rs2_i);
            default: cond = 1'b0;
        endcase
    end

    assign taken    = cond & ~illegal;
    assign mispred  = ~illegal & (taken ^ pred_taken_i);
    assign upd      = acc & ~illegal;
    assign target_d = taken ? (pc_i + imm_i) : (pc_i + XLEN'(4));

    always_comb begin
        ctr_d = bht_q[res_idx];
        if (taken && bht_q[res_idx] != 2'b11) begin
            ctr_d = bht_q[res_idx] + 2'b01;
        end else if (!taken && bht_q[res_idx] != 2'b00) begin
            ctr_d = bht_q[res_idx] - 2'b01;
        end
    end

    assign branch_cnt_d  = branch_cnt_q + PERF_W'(1);
    assign mispred_cnt_d = mispred ? (mispred_cnt_q + PERF_W'(1)) : mispred_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[IDX_W'(i)] <= CNT_INIT;
            end
            out_valid_q   <= 1'b0;
            take_q        <= 1'b0;
            mispred_q     <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            out_valid_q <= acc;
            if (acc) begin
                take_q     <= taken;
                mispred_q  <= mispred;
                illegal_q  <= illegal;
                redirect_q <= target_d;
            end
            if (upd) begin
                bht_q[res_idx] <= ctr_d;
                branch_cnt_q   <= branch_cnt_d;
                mispred_cnt_q  <= mispred_cnt_d;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign take_branch_o = take_q;
    assign mispredict_o  = mispred_q;
    assign illegal_o     = illegal_q;
    assign redirect_pc_o = redirect_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, hand-written
// multi-cycle sequences and random traffic against a behavioural model.
module tb_branch_unit;
    localparam int XLEN   = 32;
    localparam int PERF_W = 16;

    typedef struct {
        logic        v;
        logic        br;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pt;
        logic        fl;
        logic [31:0] ppc;
    } req_t;

    typedef struct {
        req_t        r;
        logic        take;
        logic [31:0] redir;
        logic        ill;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              valid_i, branch_i, pred_taken_i, flush_i;
    logic [2:0]        funct3_i;
    logic [XLEN-1:0]   rs1_i, rs2_i, pc_i, imm_i, pred_pc_i, redirect_pc_o;
    logic              pred_taken_o, out_valid_o, take_branch_o, mispredict_o, illegal_o;
    logic [PERF_W-1:0] branch_cnt_o, mispred_cnt_o;

    branch_unit #(.XLEN(XLEN), .BHT_ENTRIES(16), .CNT_INIT(2'b01), .PERF_W(PERF_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
        .valid_i(valid_i), .branch_i(branch_i), .funct3_i(funct3_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imm_i(imm_i),
        .pred_taken_i(pred_taken_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .take_branch_o(take_branch_o),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o), .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    // scoreboard and model state
    int unsigned     n_vec = 0;
    int unsigned     n_err = 0;
    int              m_bht [16];
    logic [15:0]     m_bcnt, m_mcnt;
    logic            m_take, m_misp, m_ill;
    logic [31:0]     m_redir;
    logic [34:0]     exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bcnt = '0; m_mcnt = '0;
        m_take = 1'b0; m_misp = 1'b0; m_ill = 1'b0; m_redir = '0;
        exp_q.delete();
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic req_t idle(input logic [31:0] ppc);
        req_t r;
        r = '{v: 1'b0, br: 1'b0, f3: 3'b000, a: 0, b: 0, pc: 0, imm: 0, pt: 1'b0, fl: 1'b0, ppc: ppc};
        return r;
    endfunction

    function automatic req_t br_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] pc, input logic [31:0] imm, input logic pt);
        req_t r;
        r = '{v: 1'b1, br: 1'b1, f3: f3, a: a, b: b, pc: pc, imm: imm, pt: pt, fl: 1'b0, ppc: pc};
        return r;
    endfunction

    // driver: one cycle per call, all outputs checked against the model
    task automatic step(input req_t r);
        logic        acc, ill, tk, ms;
        logic [31:0] rd;
        logic [34:0] got;
        int          idx;
        @(negedge clk);
        valid_i = r.v; branch_i = r.br; funct3_i = r.f3; rs1_i = r.a; rs2_i = r.b;
        pc_i = r.pc; imm_i = r.imm; pred_taken_i = r.pt; flush_i = r.fl; pred_pc_i = r.ppc;
        #1;
        chk("pred_taken", pred_taken_o, m_bht[(r.ppc >> 2) % 16] >= 2);
        acc = r.v && r.br && !r.fl;
        if (acc) begin
            ill = (r.f3 == 3'b010) || (r.f3 == 3'b011);
            tk  = ref_taken(r.f3, r.a, r.b);
            ms  = !ill && (tk != r.pt);
            rd  = tk ? r.pc + r.imm : r.pc + 32'd4;
            exp_q.push_back({ill, ms, tk, rd});
            if (!ill) begin
                idx = (r.pc >> 2) % 16;
                m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
                m_bcnt = m_bcnt + 16'd1;
                if (ms) m_mcnt = m_mcnt + 16'd1;
            end
            m_take = tk; m_misp = ms; m_ill = ill; m_redir = rd;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid_o, acc);
        if (out_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("result_redirect", redirect_pc_o, got[31:0]);
                chk("result_flags", {take_branch_o, mispredict_o, illegal_o}, {got[32], got[33], got[34]});
            end
        end
        chk("take_hold", take_branch_o, m_take);
        chk("misp_hold", mispredict_o, m_misp);
        chk("ill_hold", illegal_o, m_ill);
        chk("redir_hold", redirect_pc_o, m_redir);
        chk("branch_cnt", branch_cnt_o, m_bcnt);
        chk("mispred_cnt", mispred_cnt_o, m_mcnt);
    endtask

    task automatic peek(input logic [31:0] ppc, input logic exp, input string name);
        @(negedge clk);
        valid_i = 1'b0; pred_pc_i = ppc;
        #1;
        chk(name, pred_taken_o, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; branch_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b1;
    endtask

    vec_t vecs [12];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bc0, mc0;
        req_t        r;
        valid_i = 0; branch_i = 0; funct3_i = 0; rs1_i = 0; rs2_i = 0; pc_i = 0;
        imm_i = 0; pred_taken_i = 0; flush_i = 0; pred_pc_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_redirect", redirect_pc_o, 0);
        chk("rst_flags", {take_branch_o, mispredict_o, illegal_o}, 0);
        chk("rst_cnts", {branch_cnt_o, mispred_cnt_o}, 0);

        // first branch after reset: weakly not-taken prediction, BEQ taken
        peek(32'h100, 1'b0, "first_pred");
        step(br_req(3'b000, 5, 5, 32'h100, 32'h20, 1'b0));
        chk("first_valid", out_valid_o, 1);
        chk("first_take", take_branch_o, 1);
        chk("first_misp", mispredict_o, 1);
        chk("first_redir", redirect_pc_o, 32'h120);
        chk("first_bcnt", branch_cnt_o, 1);
        chk("first_mcnt", mispred_cnt_o, 1);
        step(idle(0));

        // directed table
        vecs[0]  = '{br_req(3'b000, 5, 5, 32'h100, 32'h20, 0),                 1, 32'h120, 0};
        vecs[1]  = '{br_req(3'b100, 32'hFFFFFFFF, 1, 32'h200, 32'h10, 0),      1, 32'h210, 0};
        vecs[2]  = '{br_req(3'b110, 32'hFFFFFFFF, 1, 32'h200, 32'h10, 0),      0, 32'h204, 0};
        vecs[3]  = '{br_req(3'b101, 32'hFFFFFFFF, 1, 32'h200, 32'h10, 1),      0, 32'h204, 0};
        vecs[4]  = '{br_req(3'b111, 32'hFFFFFFFF, 1, 32'h200, 32'h10, 1),      1, 32'h210, 0};
        vecs[5]  = '{br_req(3'b001, 3, 3, 32'h300, 32'h8, 0),                  0, 32'h304, 0};
        vecs[6]  = '{br_req(3'b001, 3, 4, 32'h300, 32'h8, 0),                  1, 32'h308, 0};
        vecs[7]  = '{br_req(3'b010, 7, 7, 32'h300, 32'h8, 1),                  0, 32'h304, 1};
        vecs[8]  = '{br_req(3'b011, 7, 7, 32'h300, 32'h8, 0),                  0, 32'h304, 1};
        vecs[9]  = '{br_req(3'b000, 0, 0, 32'hFFFFFFF0, 32'h20, 0),            1, 32'h10, 0};
        vecs[10] = '{br_req(3'b100, 1, 32'hFFFFFFFF, 32'h500, 32'hFFFFFFF0, 0), 0, 32'h504, 0};
        vecs[11] = '{br_req(3'b111, 0, 0, 32'h500, 32'hFFFFFFF0, 0),           1, 32'h4F0, 0};
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].r);
            chk("tbl_take", take_branch_o, vecs[i].take);
            chk("tbl_redir", redirect_pc_o, vecs[i].redir);
            chk("tbl_ill", illegal_o, vecs[i].ill);
        end

        // counter saturation at pc 0x40
        do_reset();
        for (int i = 0; i < 4; i++) step(br_req(3'b000, 0, 0, 32'h40, 32'h8, 1'b1));
        peek(32'h40, 1'b1, "sat_hi_pred");
        step(br_req(3'b001, 0, 0, 32'h40, 32'h8, 1'b1));
        peek(32'h40, 1'b1, "sat_two_pred");
        for (int i = 0; i < 4; i++) step(br_req(3'b001, 0, 0, 32'h40, 32'h8, 1'b0));
        step(br_req(3'b000, 0, 0, 32'h40, 32'h8, 1'b0));
        peek(32'h40, 1'b0, "sat_lo_pred");

        // same-cycle hazard: counter 1 -> 2 while predicting the same entry
        step(br_req(3'b000, 0, 0, 32'h40, 32'h8, 1'b0));
        chk("hazard_cnt", branch_cnt_o, 11);
        peek(32'h40, 1'b1, "hazard_next_pred");

        // illegal funct3 and flushed request leave state untouched
        bc0 = branch_cnt_o; mc0 = mispred_cnt_o;
        step(br_req(3'b010, 9, 9, 32'h40, 32'h8, 1'b1));
        chk("ill_flag", illegal_o, 1);
        chk("ill_misp", mispredict_o, 0);
        r = br_req(3'b000, 0, 0, 32'h40, 32'h8, 1'b1);
        r.fl = 1'b1;
        step(r);
        chk("flush_valid", out_valid_o, 0);
        chk("flush_bcnt", branch_cnt_o, bc0);
        chk("flush_mcnt", mispred_cnt_o, mc0);
        peek(32'h40, 1'b1, "flush_pred");
        r = br_req(3'b000, 0, 0, 32'h44, 32'h8, 1'b0);
        r.br = 1'b0;
        step(r);

        // reset mid-request
        @(negedge clk);
        valid_i = 1'b1; branch_i = 1'b1; funct3_i = 3'b000; rs1_i = 0; rs2_i = 0;
        pc_i = 32'hFFFFFFF0; imm_i = 32'h20; flush_i = 1'b0; pred_pc_i = 32'h40;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_redir", redirect_pc_o, 0);
        chk("mid_rst_flags", {take_branch_o, mispredict_o, illegal_o}, 0);
        chk("mid_rst_cnts", {branch_cnt_o, mispred_cnt_o}, 0);
        chk("mid_rst_bht", pred_taken_o, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        rst_n = 1'b1;
        step(idle(32'h40));

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r.v   = ($urandom_range(0, 3) != 0);
            r.br  = ($urandom_range(0, 7) != 0);
            r.fl  = ($urandom_range(0, 9) == 0);
            r.f3  = 3'($urandom_range(0, 7));
            r.a   = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd1;
            r.b   = ($urandom_range(0, 3) == 0) ? r.a : $urandom();
            r.pc  = ($urandom_range(0, 1) != 0) ? {26'd0, 4'($urandom_range(0, 3)), 2'b00} : $urandom() & 32'hFFFFFFFC;
            r.imm = $urandom() & 32'hFFFFFFFE;
            r.pt  = ($urandom_range(0, 1) != 0);
            r.ppc = ($urandom_range(0, 1) != 0) ? r.pc : $urandom();
            step(r);
        end
        step(idle(0));
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
